// File: rtl/cordic_acc_top.sv
// Avalon-MM FP32 accumulator: samples queue in a small FIFO and are summed into acc
// by a four-stage add FSM (align, add, normalise, round-to-nearest-even).
module cordic_acc_top #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        waitrequest
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound} state_e;

    state_e             state_q, state_d;
    logic [31:0]        fifo_mem_q [FIFO_DEPTH];
    logic [31:0]        fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [31:0]        readdata_q, readdata_d;
    logic [31:0]        acc_q, acc_d, x_q, x_d;
    logic               spec_q, spec_d, sign_q, sign_d, sub_q, sub_d;
    logic [31:0]        spec_val_q, spec_val_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [26:0]        big_q, big_d, small_q, small_d, n_q, n_d;
    logic [27:0]        sum_q, sum_d;

    logic full, busy, push, pop, load, rd_ok;

    always_comb begin : bus_fifo
        full        = (count_q == CW'(FIFO_DEPTH));
        busy        = (count_q != '0) || (state_q != StIdle);
        push        = write && !address && !full;
        pop         = (state_q == StIdle) && (count_q != '0);
        load        = write && address && !busy;
        // A pending write always wins; a concurrent read simply does not complete.
        rd_ok       = read && !write && (!address || !busy);
        waitrequest = write ? (address ? busy : full) : (read && address && busy);
        fifo_mem_d  = fifo_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = writedata;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d    = count_q + CW'(push) - CW'(pop);
        readdata_d = readdata_q;
        if (rd_ok) readdata_d = address ? acc_q : {31'b0, busy};
    end

    assign readdata = readdata_d;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd0;
        for (int i = 0; i <= 26; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    logic [7:0]  a_exp, x_exp, diff;
    logic        a_nan, x_nan, a_inf, x_inf, a_zero, x_zero, a_big, big_sign, spec_v;
    logic [31:0] spec_r;
    logic [30:0] big_mag, small_mag;
    logic [26:0] big_m, small_full, small_m, mask;

    always_comb begin : align_stage
        a_exp  = acc_q[30:23];
        x_exp  = x_q[30:23];
        a_nan  = (a_exp == 8'hFF) && (acc_q[22:0] != '0);
        x_nan  = (x_exp == 8'hFF) && (x_q[22:0] != '0);
        a_inf  = (a_exp == 8'hFF) && (acc_q[22:0] == '0);
        x_inf  = (x_exp == 8'hFF) && (x_q[22:0] == '0);
        a_zero = (a_exp == 8'h00);
        x_zero = (x_exp == 8'h00);
        spec_v = 1'b1;
        spec_r = QNAN;
        if (a_nan || x_nan || (a_inf && x_inf && (acc_q[31] != x_q[31]))) spec_r = QNAN;
        else if (a_inf)              spec_r = acc_q;
        else if (x_inf)              spec_r = x_q;
        else if (a_zero && x_zero)   spec_r = {acc_q[31] & x_q[31], 31'b0};
        else if (a_zero)             spec_r = x_q;
        else if (x_zero)             spec_r = acc_q;
        else                         spec_v = 1'b0;
        a_big      = (acc_q[30:0] >= x_q[30:0]);
        big_mag    = a_big ? acc_q[30:0] : x_q[30:0];
        small_mag  = a_big ? x_q[30:0] : acc_q[30:0];
        big_sign   = a_big ? acc_q[31] : x_q[31];
        diff       = big_mag[30:23] - small_mag[30:23];
        big_m      = {1'b1, big_mag[22:0], 3'b000};
        small_full = {1'b1, small_mag[22:0], 3'b000};
        mask       = '0;
        if (diff >= 8'd27) begin
            small_m = 27'd1;
        end else begin
            mask       = (27'd1 << diff) - 27'd1;
            small_m    = small_full >> diff;
            small_m[0] = small_m[0] | (|(small_full & mask));
        end
    end

    logic [27:0]       sum_c;
    logic [4:0]        lz;
    logic [26:0]       norm_n;
    logic signed [9:0] norm_e, rnd_e;
    logic              rnd_up;
    logic [23:0]       rnd_f;
    logic [31:0]       result;

    always_comb begin : arith_stages
        sum_c = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
        lz    = lzc27(sum_q[26:0]);
        if (sum_q[27]) begin
            norm_n = {sum_q[27:2], sum_q[1] | sum_q[0]};
            norm_e = exp_q + 10'sd1;
        end else begin
            norm_n = sum_q[26:0] << lz;
            norm_e = exp_q - $signed({5'b0, lz});
        end
        // n_q[26] is the hidden bit; it is clear only for an exact-zero sum.
        rnd_up = n_q[2] & (n_q[1] | n_q[0] | n_q[3]);
        rnd_f  = {1'b0, n_q[25:3]} + 24'(rnd_up);
        rnd_e  = exp_q + $signed({9'b0, rnd_f[23]});
        if (spec_q)                          result = spec_val_q;
        else if (!n_q[26] || exp_q < 10'sd1) result = '0;
        else if (rnd_e >= 10'sd255)          result = {sign_q, 8'hFF, 23'd0};
        else                                 result = {sign_q, rnd_e[7:0], rnd_f[22:0]};
    end

    always_comb begin : adder_fsm
        state_d    = state_q;
        x_d        = x_q;
        acc_d      = acc_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        sign_d     = sign_q;
        sub_d      = sub_q;
        exp_d      = exp_q;
        big_d      = big_q;
        small_d    = small_q;
        sum_d      = sum_q;
        n_d        = n_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    x_d     = fifo_mem_q[rd_ptr_q];
                    state_d = StAlign;
                end else if (load) begin
                    acc_d = writedata;
                end
            end
            StAlign: begin
                spec_d     = spec_v;
                spec_val_d = spec_r;
                sign_d     = big_sign;
                sub_d      = acc_q[31] ^ x_q[31];
                exp_d      = {2'b00, big_mag[30:23]};
                big_d      = big_m;
                small_d    = small_m;
                state_d    = StAdd;
            end
            StAdd: begin
                sum_d   = sum_c;
                state_d = StNorm;
            end
            StNorm: begin
                n_d     = norm_n;
                exp_d   = norm_e;
                state_d = StRound;
            end
            StRound: begin
                acc_d   = result;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            fifo_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            readdata_q <= '0;
            acc_q      <= '0;
            x_q        <= '0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            exp_q      <= '0;
            big_q      <= '0;
            small_q    <= '0;
            sum_q      <= '0;
            n_q        <= '0;
        end else begin
            state_q    <= state_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            readdata_q <= readdata_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            sign_q     <= sign_d;
            sub_q      <= sub_d;
            exp_q      <= exp_d;
            big_q      <= big_d;
            small_q    <= small_d;
            sum_q      <= sum_d;
            n_q        <= n_d;
        end
    end

endmodule

// File: tb/tb_cordic_acc_top.sv
// Directed bench for cordic_acc_top: bus tasks drive Avalon transfers, expected sums are
// hand-computed FP32 constants.
module tb_cordic_acc_top;
    logic        clk = 1'b0;
    logic        reset, address, write, read;
    logic [31:0] writedata, readdata;
    logic        waitrequest;

    int total = 0;
    int bad   = 0;
    localparam int Bound = 40;
    localparam int NV = 16;

    always #5 clk = ~clk;

    cordic_acc_top #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .write      (write),
        .writedata  (writedata),
        .read       (read),
        .readdata   (readdata),
        .waitrequest(waitrequest)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic a, input logic [31:0] d, output int waits);
        address   = a;
        writedata = d;
        write     = 1'b1;
        waits     = 0;
        @(negedge clk);
        while (waitrequest && waits < Bound) begin
            waits++;
            @(negedge clk);
        end
        if (waitrequest) check_eq("write_timeout", {31'b0, waitrequest}, 32'd0);
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    task automatic bus_read(input logic a, output logic [31:0] d, output int waits);
        address = a;
        read    = 1'b1;
        waits   = 0;
        @(negedge clk);
        while (waitrequest && waits < Bound) begin
            waits++;
            @(negedge clk);
        end
        if (waitrequest) check_eq("read_timeout", {31'b0, waitrequest}, 32'd0);
        d = readdata;
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    logic [31:0] va [NV] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF,
                             32'h7F800000, 32'h00000000, 32'h3F800001, 32'h80000000,
                             32'h7F800000, 32'h3F800000, 32'h40000000, 32'h3FC00000,
                             32'h00800000, 32'hFF7FFFFF, 32'h3F800000, 32'h00000000};
    logic [31:0] vx [NV] = '{32'hBF800000, 32'h33800000, 32'h33800001, 32'h7F7FFFFF,
                             32'hFF800000, 32'h00000001, 32'h33800000, 32'h80000000,
                             32'h3F800000, 32'h7F800001, 32'hB3800000, 32'hBF800000,
                             32'h80800001, 32'hFF7FFFFF, 32'h32800000, 32'hC0400000};
    logic [31:0] vr [NV] = '{32'h00000000, 32'h3F800000, 32'h3F800001, 32'h7F800000,
                             32'h7FC00000, 32'h00000000, 32'h3F800002, 32'h80000000,
                             32'h7F800000, 32'h7FC00000, 32'h40000000, 32'h3F000000,
                             32'h00000000, 32'hFF800000, 32'h3F800000, 32'hC0400000};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int          w;
        int          ws [6];

        reset = 1'b1; address = 1'b0; write = 1'b0; read = 1'b0; writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_readdata", readdata, 32'd0);
        check_eq("rst_wait", {31'b0, waitrequest}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus_read(1'b1, d, w);
        check_eq("t1_acc", d, 32'd0);
        check_eq("t1_acc_wait", w, 32'd0);
        bus_read(1'b0, d, w);
        check_eq("t1_status", d, 32'd0);

        bus_write(1'b1, 32'h0, w);
        bus_write(1'b0, 32'h437F0000, w);
        bus_write(1'b0, 32'h43000000, w);
        bus_read(1'b1, d, w);
        check_eq("t2_sum", d, 32'h43BF8000);
        check_eq("t2_stalled", 32'(w > 0), 32'd1);
        check_eq("t2_within10", 32'(w <= 10), 32'd1);

        bus_write(1'b1, 32'h0, w);
        bus_write(1'b0, 32'h3F800000, w);
        bus_read(1'b1, d, w);
        check_eq("lat_sum", d, 32'h3F800000);
        check_eq("lat_bound", 32'(w <= 5), 32'd1);

        for (int i = 0; i < NV; i++) begin
            bus_write(1'b1, va[i], w);
            bus_write(1'b0, vx[i], w);
            bus_read(1'b1, d, w);
            check_eq($sformatf("vec%0d", i), d, vr[i]);
        end

        bus_write(1'b1, 32'h0, w);
        for (int i = 0; i < 6; i++) bus_write(1'b0, 32'h3F800000, ws[i]);
        for (int i = 0; i < 5; i++) check_eq($sformatf("t5_nowait%0d", i), ws[i], 32'd0);
        check_eq("t5_full_wait", 32'(ws[5] > 0), 32'd1);
        bus_read(1'b0, d, w);
        check_eq("t5_status_busy", d, 32'd1);
        check_eq("t5_status_nowait", w, 32'd0);
        bus_read(1'b1, d, w);
        check_eq("t5_sum", d, 32'h40C00000);

        bus_write(1'b1, 32'h3F800000, w);
        for (int i = 0; i < 3; i++) bus_write(1'b0, 32'h3F800000, w);
        // First sample is now in ADD; two more edges put it in ROUND.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("t6_readdata", readdata, 32'd0);
        check_eq("t6_wait", {31'b0, waitrequest}, 32'd0);
        bus_read(1'b0, d, w);
        check_eq("t6_status", d, 32'd0);
        bus_read(1'b1, d, w);
        check_eq("t6_acc", d, 32'd0);
        check_eq("t6_acc_wait", w, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        bus_read(1'b1, d, w);
        check_eq("t6_acc_late", d, 32'd0);
        bus_read(1'b0, d, w);
        check_eq("t6_status_late", d, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
